// File: rtl/axi4_txn_scheduler.sv
// Round-robin write/read transaction scheduler feeding the AXI4 master, with per-direction outstanding caps.
// Optional per-direction watchdog is enabled by defining AXI_SCHED_TIMEOUT_EN.
module axi4_txn_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3,
  parameter int TMR_W           = 10
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             wr_rsp_en,
  input  logic             rd_rsp_en,
  output logic             wr_trn_en,
  output logic             rd_trn_en,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic             wr_stall,
  output logic             rd_stall,
  output logic             protocol_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE_W, ISSUE_R, GAP} state_t;

  state_t           r_state, w_next;
  logic             r_last_wr;
  logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;
  logic             r_perr;
  logic             w_wr_elig, w_rd_elig, w_wr_inc, w_rd_inc, w_wr_err, w_rd_err;

  assign w_wr_elig = wr_req && (r_wr_cnt < MAX_CNT);
  assign w_rd_elig = rd_req && (r_rd_cnt < MAX_CNT);
  assign w_wr_inc  = (r_state == ISSUE_W);
  assign w_rd_inc  = (r_state == ISSUE_R);
  assign w_wr_err  = wr_rsp_en && !w_wr_inc && (r_wr_cnt == '0);
  assign w_rd_err  = rd_rsp_en && !w_rd_inc && (r_rd_cnt == '0);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_last_wr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wr_inc) r_last_wr <= 1'b1;
      if (w_rd_inc) r_last_wr <= 1'b0;
    end
  end

  // Tie goes to the direction not granted last; GAP gives the decoder a cycle to advance its request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_elig && (!w_rd_elig || !r_last_wr))
          w_next = ISSUE_W;
        else if (w_rd_elig)
          w_next = ISSUE_R;
      end
      ISSUE_W: w_next = GAP;
      ISSUE_R: w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Issue and response in the same cycle cancel; a response against an empty count is an error.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_perr   <= 1'b0;
    end else begin
      if (w_wr_inc && !wr_rsp_en)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      else if (!w_wr_inc && wr_rsp_en && (r_wr_cnt != '0))
        r_wr_cnt <= r_wr_cnt - 1'b1;
      if (w_rd_inc && !rd_rsp_en)
        r_rd_cnt <= r_rd_cnt + 1'b1;
      else if (!w_rd_inc && rd_rsp_en && (r_rd_cnt != '0))
        r_rd_cnt <= r_rd_cnt - 1'b1;
      if (w_wr_err || w_rd_err) r_perr <= 1'b1;
    end
  end

  assign wr_trn_en      = w_wr_inc;
  assign rd_trn_en      = w_rd_inc;
  assign wr_outstanding = r_wr_cnt;
  assign rd_outstanding = r_rd_cnt;
  assign wr_stall       = wr_req && (r_wr_cnt == MAX_CNT);
  assign rd_stall       = rd_req && (r_rd_cnt == MAX_CNT);
  assign protocol_err   = r_perr;

`ifdef AXI_SCHED_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMR_MAX = '1;

  logic [TMR_W-1:0] r_wr_tmr, r_rd_tmr;
  logic             r_timeout;

  // Watchdog counts cycles with work in flight and no response; saturates at the limit.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wr_tmr  <= '0;
      r_rd_tmr  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (wr_rsp_en || (r_wr_cnt == '0))
        r_wr_tmr <= '0;
      else if (r_wr_tmr != TMR_MAX)
        r_wr_tmr <= r_wr_tmr + 1'b1;
      if (rd_rsp_en || (r_rd_cnt == '0))
        r_rd_tmr <= '0;
      else if (r_rd_tmr != TMR_MAX)
        r_rd_tmr <= r_rd_tmr + 1'b1;
      if ((r_wr_tmr == TMR_MAX) || (r_rd_tmr == TMR_MAX)) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_txn_scheduler.sv
// Directed self-checking bench for axi4_txn_scheduler: reset, round-robin, caps, same-cycle update, error/timeout.
module tb_axi4_txn_scheduler;
  logic       ACLK = 1'b0;
  logic       ARESETn, wr_req, rd_req, wr_rsp_en, rd_rsp_en;
  logic       wr_trn_en, rd_trn_en, wr_stall, rd_stall, protocol_err, timeout;
  logic [2:0] wr_outstanding, rd_outstanding;
  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi4_txn_scheduler #(.MAX_OUTSTANDING(4), .CNT_W(3), .TMR_W(10)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .wr_req(wr_req), .rd_req(rd_req),
    .wr_rsp_en(wr_rsp_en), .rd_rsp_en(rd_rsp_en), .wr_trn_en(wr_trn_en), .rd_trn_en(rd_trn_en),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .wr_stall(wr_stall), .rd_stall(rd_stall), .protocol_err(protocol_err), .timeout(timeout)
  );

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset;
    wr_req = 0; rd_req = 0; wr_rsp_en = 0; rd_rsp_en = 0;
    ARESETn = 0;
    tick; tick;
    ARESETn = 1;
  endtask

  task automatic test_reset;
    wr_req = 1; rd_req = 1; wr_rsp_en = 0; rd_rsp_en = 0; ARESETn = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({wr_trn_en, rd_trn_en, wr_outstanding, rd_outstanding, wr_stall, rd_stall, protocol_err, timeout} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got wt=%b rt=%b wo=%0d ro=%0d ws=%b rs=%b pe=%b to=%b, want all 0",
                 i, wr_trn_en, rd_trn_en, wr_outstanding, rd_outstanding, wr_stall, rd_stall, protocol_err, timeout);
      end
    end
    ARESETn = 1;
    tick;
    total++;
    if (wr_trn_en !== 1'b1) begin bad++; $display("FAIL reset_first_wr: wr_trn_en=%b want 1", wr_trn_en); end
    total++;
    if (rd_trn_en !== 1'b0) begin bad++; $display("FAIL reset_first_rd: rd_trn_en=%b want 0", rd_trn_en); end
  endtask

  task automatic test_round_robin;
    int pc[8];
    bit pw[8];
    int np = 0;
    bit both = 0;
    logic [4:0] wsh = '0, rsh = '0;
    do_reset;
    wr_req = 1; rd_req = 1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (wr_trn_en && rd_trn_en) both = 1;
      if ((wr_trn_en || rd_trn_en) && np < 8) begin
        pc[np] = c; pw[np] = wr_trn_en; np++;
      end
      wr_rsp_en = wsh[4]; rd_rsp_en = rsh[4];
      wsh = {wsh[3:0], wr_trn_en};
      rsh = {rsh[3:0], rd_trn_en};
    end
    wr_req = 0; rd_req = 0; wr_rsp_en = 0; rd_rsp_en = 0;
    total++;
    if (np < 6) begin bad++; $display("FAIL rr_pulse_count: got %0d want >=6", np); end
    for (int i = 0; i < 6 && i < np; i++) begin
      bit exp_w;
      int exp_c;
      exp_w = (i % 2 == 0);
      exp_c = 1 + 3 * i;
      total++;
      if (pw[i] !== exp_w) begin bad++; $display("FAIL rr_dir[%0d]: is_write=%b want %b", i, pw[i], exp_w); end
      total++;
      if (pc[i] !== exp_c) begin bad++; $display("FAIL rr_cycle[%0d]: cycle %0d want %0d", i, pc[i], exp_c); end
    end
    total++;
    if (both !== 1'b0) begin bad++; $display("FAIL rr_exclusive: both pulses seen together"); end
    total++;
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL rr_no_err: protocol_err=%b want 0", protocol_err); end
  endtask

  task automatic test_cap;
    int wp = 0;
    bit found = 0;
    do_reset;
    wr_req = 1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (wr_trn_en) wp++;
    end
    total++;
    if (wp !== 4) begin bad++; $display("FAIL cap_pulses: got %0d want 4", wp); end
    total++;
    if (wr_outstanding !== 3'd4) begin bad++; $display("FAIL cap_count: got %0d want 4", wr_outstanding); end
    total++;
    if (wr_stall !== 1'b1) begin bad++; $display("FAIL cap_stall: got %b want 1", wr_stall); end
    wr_rsp_en = 1;
    tick;
    wr_rsp_en = 0;
    total++;
    if (wr_outstanding !== 3'd3) begin bad++; $display("FAIL cap_retire: got %0d want 3", wr_outstanding); end
    for (int c = 0; c < 10 && !found; c++) begin
      tick;
      if (wr_trn_en) found = 1;
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL cap_fifth_pulse: no wr_trn_en within 10 cycles"); end
    tick; tick;
    total++;
    if (wr_outstanding !== 3'd4) begin bad++; $display("FAIL cap_refill: got %0d want 4", wr_outstanding); end
    wr_req = 0;
  endtask

  task automatic test_cap_one_side;
    int wp = 0, rp = 0;
    do_reset;
    rd_req = 1;
    for (int c = 0; c < 20; c++) tick;
    total++;
    if (rd_outstanding !== 3'd4) begin bad++; $display("FAIL side_rd_fill: got %0d want 4", rd_outstanding); end
    wr_req = 1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (wr_trn_en) wp++;
      if (rd_trn_en) rp++;
    end
    total++;
    if (wp !== 4) begin bad++; $display("FAIL side_wr_pulses: got %0d want 4", wp); end
    total++;
    if (rp !== 0) begin bad++; $display("FAIL side_rd_pulses: got %0d want 0", rp); end
    total++;
    if (rd_stall !== 1'b1) begin bad++; $display("FAIL side_rd_stall: got %b want 1", rd_stall); end
    total++;
    if (wr_outstanding !== 3'd4) begin bad++; $display("FAIL side_wr_count: got %0d want 4", wr_outstanding); end
    wr_req = 0; rd_req = 0;
  endtask

  task automatic test_simultaneous;
    bit hit = 0;
    do_reset;
    wr_req = 1;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick;
      if (wr_trn_en && wr_outstanding == 3'd2) hit = 1;
    end
    total++;
    if (hit !== 1'b1) begin bad++; $display("FAIL simul_reach: third issue with count 2 not seen"); end
    wr_rsp_en = 1; wr_req = 0;
    tick;
    wr_rsp_en = 0;
    total++;
    if (wr_outstanding !== 3'd2) begin bad++; $display("FAIL simul_count: got %0d want 2", wr_outstanding); end
    total++;
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL simul_no_err: got %b want 0", protocol_err); end
  endtask

  task automatic test_error_timeout;
    logic exp_to;
`ifdef AXI_SCHED_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    do_reset;
    rd_rsp_en = 1;
    tick;
    rd_rsp_en = 0;
    total++;
    if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", protocol_err); end
    total++;
    if (rd_outstanding !== 3'd0) begin bad++; $display("FAIL err_count: got %0d want 0", rd_outstanding); end
    tick; tick; tick;
    total++;
    if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", protocol_err); end
    do_reset;
    total++;
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", protocol_err); end
    wr_req = 1;
    tick;
    wr_req = 0;
    total++;
    if (wr_trn_en !== 1'b1) begin bad++; $display("FAIL to_issue: wr_trn_en=%b want 1", wr_trn_en); end
    repeat (900) tick;
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout); end
    total++;
    if (wr_outstanding !== 3'd1) begin bad++; $display("FAIL to_count: got %0d want 1", wr_outstanding); end
    repeat (200) tick;
    total++;
    if (timeout !== exp_to) begin bad++; $display("FAIL to_flag: got %b want %b", timeout, exp_to); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_cap;
    test_cap_one_side;
    test_simultaneous;
    test_error_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
